// File: rtl/arb_mux.sv
// rtl/arb_mux.sv - N-to-1 arbitrating mux with one registered output beat.
// Define ARB_MUX_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed
// priority, with the lowest-indexed valid channel winning.
module arb_mux #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 8,
  parameter int SEL_WIDTH = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [CHANNELS-1:0]       d_valid,
  output logic [CHANNELS-1:0]       d_ready,
  output logic [WIDTH-1:0]          y,
  output logic                      y_valid,
  input  logic                      y_ready,
  output logic [SEL_WIDTH-1:0]      sel
);

  logic [WIDTH-1:0]     y_q, y_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic                 y_valid_q, y_valid_d;
  logic                 load;
  logic                 grant_any;
  logic [SEL_WIDTH-1:0] grant_idx;

  // The output register can take a beat when it is empty or being drained.
  assign load = !y_valid_q || y_ready;

`ifdef ARB_MUX_ROUND_ROBIN_EN
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;

  // Round-robin search: scan downward so the last hit is the channel closest to ptr.
  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (d_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = SEL_WIDTH'(idx);
      end
    end
  end

  // Move the pointer just past the winner; hold it when nothing is granted.
  always_comb begin
    ptr_d = ptr_q;
    if (load && grant_any) begin
      if (grant_idx == SEL_WIDTH'(CHANNELS - 1)) ptr_d = '0;
      else                                       ptr_d = grant_idx + SEL_WIDTH'(1);
    end
  end

  // Priority pointer register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  // Fixed priority: scan downward so the lowest valid index wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (d_valid[k]) begin
        grant_any = 1'b1;
        grant_idx = SEL_WIDTH'(k);
      end
    end
  end
`endif

  // One-hot ready for the winner; held low during reset so no beat is consumed.
  always_comb begin
    d_ready = '0;
    if (reset && load && grant_any) d_ready[grant_idx] = 1'b1;
  end

  // Load the granted beat, drain to empty when idle, hold while stalled.
  always_comb begin
    y_d       = y_q;
    sel_d     = sel_q;
    y_valid_d = y_valid_q;
    if (load) begin
      y_valid_d = grant_any;
      if (grant_any) begin
        y_d   = d[int'(grant_idx)*WIDTH +: WIDTH];
        sel_d = grant_idx;
      end
    end
  end

  // Output beat register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      y_q       <= '0;
      sel_q     <= '0;
      y_valid_q <= 1'b0;
    end else begin
      y_q       <= y_d;
      sel_q     <= sel_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign y       = y_q;
  assign sel     = sel_q;
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_arb_mux.sv
// tb/tb_arb_mux.sv - directed self-checking bench for arb_mux (8- and 3-channel instances).
module tb_arb_mux;

  logic        clock;
  logic        reset;
  logic [63:0] d;
  logic [7:0]  d_valid, d_ready, y;
  logic        y_valid, y_ready;
  logic [2:0]  sel;

  logic [23:0] d3;
  logic [2:0]  d_valid3, d_ready3;
  logic [7:0]  y3;
  logic        y_valid3, y_ready3;
  logic [1:0]  sel3;

  int n_checks = 0;
  int n_fail   = 0;

  arb_mux #(.WIDTH(8), .CHANNELS(8), .SEL_WIDTH(3)) dut (
    .clock(clock), .reset(reset), .d(d), .d_valid(d_valid), .d_ready(d_ready),
    .y(y), .y_valid(y_valid), .y_ready(y_ready), .sel(sel)
  );

  arb_mux #(.WIDTH(8), .CHANNELS(3), .SEL_WIDTH(2)) dut3 (
    .clock(clock), .reset(reset), .d(d3), .d_valid(d_valid3), .d_ready(d_ready3),
    .y(y3), .y_valid(y_valid3), .y_ready(y_ready3), .sel(sel3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] chval(input int i);
    if (i == 5)      return 8'hA5;
    else if (i == 3) return 8'h3C;
    else             return 8'h10 + 8'(i);
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    d_valid = '0;
    d_valid3 = '0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_sel;
    reset    = 1'b0;
    y_ready  = 1'b1;
    y_ready3 = 1'b1;
    d_valid  = 8'hFF;
    d_valid3 = 3'b111;
    for (int i = 0; i < 8; i++) d[i*8 +: 8] = chval(i);
    for (int i = 0; i < 3; i++) d3[i*8 +: 8] = 8'h40 + 8'(i);

    // reset state, with every channel valid so the ready gating is exercised
    #1;
    check("rst_y_valid", 32'(y_valid), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_d_ready", 32'(d_ready), 32'd0);
    check("rst_d_ready3", 32'(d_ready3), 32'd0);
    @(posedge clock); #1;
    check("rst_y_valid_clk", 32'(y_valid), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    d_valid = '0;
    d_valid3 = '0;

    // single valid channel 5
    do_reset();
    d_valid = 8'h20;
    #1 check("single_d_ready", 32'(d_ready), 32'h20);
    @(posedge clock); #1;
    check("single_y", 32'(y), 32'hA5);
    check("single_sel", 32'(sel), 32'd5);
    check("single_y_valid", 32'(y_valid), 32'd1);
    @(negedge clock);
    d_valid = '0;
    #1 check("idle_d_ready", 32'(d_ready), 32'd0);
    @(posedge clock); #1;
    check("idle_y_valid", 32'(y_valid), 32'd0);
    check("idle_y_hold", 32'(y), 32'hA5);
    check("idle_sel_hold", 32'(sel), 32'd5);

    // all valid, back-to-back beats
    do_reset();
    d_valid = 8'hFF;
    for (int i = 0; i < 10; i++) begin
`ifdef ARB_MUX_ROUND_ROBIN_EN
      exp_sel = i % 8;
`else
      exp_sel = 0;
`endif
      #1 check("all_d_ready", 32'(d_ready), 32'(1) << exp_sel);
      @(posedge clock); #1;
      check("all_sel", 32'(sel), 32'(exp_sel));
      check("all_y", 32'(y), 32'(chval(exp_sel)));
      check("all_y_valid", 32'(y_valid), 32'd1);
      @(negedge clock);
    end

    // channels 1 and 2 valid
    do_reset();
    d_valid = 8'b0000_0110;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_MUX_ROUND_ROBIN_EN
      exp_sel = 1 + (i % 2);
`else
      exp_sel = 1;
`endif
      #1 check("pair_d_ready", 32'(d_ready), 32'(1) << exp_sel);
      @(posedge clock); #1;
      check("pair_sel", 32'(sel), 32'(exp_sel));
      @(negedge clock);
    end

    // stall with a held beat of 3C
    do_reset();
    d_valid = 8'h08;
    #1 check("stall_load_d_ready", 32'(d_ready), 32'h08);
    @(posedge clock); #1;
    check("stall_load_y", 32'(y), 32'h3C);
    @(negedge clock);
    y_ready = 1'b0;
    d_valid = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      #1 check("stall_d_ready", 32'(d_ready), 32'd0);
      @(posedge clock); #1;
      check("stall_y", 32'(y), 32'h3C);
      check("stall_sel", 32'(sel), 32'd3);
      check("stall_y_valid", 32'(y_valid), 32'd1);
      @(negedge clock);
    end
    y_ready = 1'b1;
`ifdef ARB_MUX_ROUND_ROBIN_EN
    exp_sel = 4;
`else
    exp_sel = 0;
`endif
    #1 check("unstall_d_ready", 32'(d_ready), 32'(1) << exp_sel);
    @(posedge clock); #1;
    check("unstall_sel", 32'(sel), 32'(exp_sel));
    check("unstall_y", 32'(y), 32'(chval(exp_sel)));
    @(negedge clock);
    d_valid = '0;

    // three-channel instance wraps
    do_reset();
    d_valid3 = 3'b111;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_MUX_ROUND_ROBIN_EN
      exp_sel = i % 3;
`else
      exp_sel = 0;
`endif
      #1 check("ch3_d_ready", 32'(d_ready3), 32'(1) << exp_sel);
      @(posedge clock); #1;
      check("ch3_sel", 32'(sel3), 32'(exp_sel));
      check("ch3_y", 32'(y3), 32'h40 + 32'(exp_sel));
      @(negedge clock);
    end
    d_valid3 = '0;

    // asynchronous reset mid-transfer
    do_reset();
    d_valid = 8'hFF;
    @(posedge clock); #1;
    check("pre_areset_y_valid", 32'(y_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("areset_y_valid", 32'(y_valid), 32'd0);
    check("areset_y", 32'(y), 32'd0);
    check("areset_sel", 32'(sel), 32'd0);
    check("areset_d_ready", 32'(d_ready), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    d_valid = 8'b1001_0000;
    #1 check("post_areset_d_ready", 32'(d_ready), 32'h10);
    @(posedge clock); #1;
    check("post_areset_sel", 32'(sel), 32'd4);
    check("post_areset_y", 32'(y), 32'h14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter WIDTH, default 8, data width of each channel in bits.
REQ-002 Parameter CHANNELS, default 8, number of input channels, legal range 2..2**SEL_WIDTH.
REQ-003 Parameter SEL_WIDTH, default 3, width of the grant index.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 d  input  CHANNELS*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 d_valid  input  CHANNELS  per-channel valid; bit i asserts that channel i offers a beat.
REQ-008 d_ready  output  CHANNELS  per-channel ready; bit i high means channel i's beat is taken this cycle.
REQ-009 y  output  WIDTH  registered output data.
REQ-010 y_valid  output  1  y holds a beat.
REQ-011 y_ready  input  1  downstream accepts y this cycle.
REQ-012 sel  output  SEL_WIDTH  index of the channel whose beat is in y.

Function
REQ-013 A transfer on any port SHALL occur only in a cycle where its valid and ready are both high.
REQ-014 Internal load SHALL equal (!y_valid || y_ready); the output register accepts a new beat only when load is high.
REQ-015 When load is high and at least one d_valid bit is high, the arbiter SHALL pick exactly one granted channel g, and d_ready SHALL be one-hot at bit g.
REQ-016 d_ready SHALL be all zero whenever load is low or no d_valid bit is high; d_ready is combinational from d_valid, y_valid and y_ready.
REQ-017 On a grant, at the next edge y <= d[g], sel <= g, y_valid <= 1; latency from acceptance to y_valid is exactly one cycle.
REQ-018 When load is high and no d_valid bit is high, y_valid SHALL clear at the next edge; y and sel SHALL hold their values.
REQ-019 When load is low, y, sel and y_valid SHALL hold; a held beat is never altered or dropped.
REQ-020 Back-to-back throughput SHALL be one beat per cycle while y_ready stays high.
REQ-021 Arbitration SHALL be round-robin: a pointer ptr (SEL_WIDTH bits) names the highest-priority channel; priority descends ptr, ptr+1, ... wrapping at CHANNELS-1 to 0.
REQ-022 After every grant g, ptr SHALL become g+1, or 0 when g = CHANNELS-1; ptr SHALL not change in cycles with no grant.
REQ-023 d_valid bits at indices >= CHANNELS do not exist; ptr SHALL never take a value >= CHANNELS.
REQ-024 A channel whose d_valid drops before it is granted SHALL not be granted, and no state changes on its behalf.

Reset
REQ-025 While reset is low, y_valid SHALL be 0, y SHALL be 0, sel SHALL be 0, ptr SHALL be 0, and d_ready SHALL be all zero, independent of clock.
REQ-026 Reset asserted mid-transfer SHALL discard the held beat; after release the first grant goes to the lowest-indexed valid channel.
REQ-027 d_ready SHALL be gated low while reset is low so no upstream beat is consumed during reset.

Configuration
REQ-028 Macro ARB_MUX_ROUND_ROBIN_EN defined: arbitration per REQ-021/REQ-022.
REQ-029 Macro ARB_MUX_ROUND_ROBIN_EN undefined: fixed priority; the lowest-indexed valid channel always wins, ptr is not implemented, and all other requirements still hold.

Verification
REQ-030 WIDTH=8, CHANNELS=8, only d_valid[5] high with d[5]=8'hA5, y_ready=1 -> d_ready=8'b0010_0000 that cycle; next cycle y=8'hA5, sel=5, y_valid=1.
REQ-031 Round-robin build, d_valid=8'hFF held, y_ready=1 for 10 cycles after reset -> sel sequence 0,1,2,3,4,5,6,7,0,1, one beat per cycle.
REQ-032 Fixed-priority build, d_valid=8'b0000_0110 held for 4 cycles -> sel is 1 on every beat; channel 2 never granted.
REQ-033 y_valid=1 with y=8'h3C, y_ready=0 for 3 cycles while d_valid=8'hFF -> d_ready=0 each cycle, y stays 8'h3C; on y_ready=1 the next grant loads in one cycle.
REQ-034 CHANNELS=3, d_valid=3'b111, y_ready=1 -> sel sequence 0,1,2,0; ptr wraps from 2 to 0 and never reaches 3.
REQ-035 reset driven low between clock edges while y_valid=1 -> y_valid, y, sel go to 0 immediately; after release with d_valid=8'b1001_0000 the first sel is 4.
